// File: rtl/gate_divider_trim.sv
// Programmable gate-pulse divider: period = DIV_GATE + signed trim + dithered fraction.
// Trim is taken over a valid/ready handshake and only becomes active on a period boundary.
module gate_divider_trim #(
    parameter int DIV_GATE    = 2000000,
    parameter int TRIM_WIDTH  = 16,
    parameter int TRIM_MAX    = 200,
    parameter int FRAC_BITS   = 8,
    parameter int EPOCH_WIDTH = 16,
    localparam int DIV_BITS   = $clog2(DIV_GATE + TRIM_MAX + 2)
) (
    input  logic                          clk_gate,
    input  logic                          rst_gate,
    input  logic                          i_en,
    input  logic signed [TRIM_WIDTH-1:0]  i_trim,
    input  logic        [FRAC_BITS-1:0]   i_frac,
    input  logic                          i_trim_valid,
    output logic                          o_trim_ready,
    output logic                          o_trim_clamped,
    output logic                          o_trim_applied,
    output logic                          o_gate,
    output logic        [DIV_BITS-1:0]    o_period,
    output logic        [EPOCH_WIDTH-1:0] o_epoch
);

    localparam int AW = DIV_BITS + 1;
    localparam logic signed [TRIM_WIDTH-1:0] TMAX_P  = TRIM_WIDTH'(TRIM_MAX);
    localparam logic signed [TRIM_WIDTH-1:0] TMAX_N  = TRIM_WIDTH'(-TRIM_MAX);
    localparam logic        [AW-1:0]         DIV_A   = AW'(DIV_GATE);
    localparam logic        [DIV_BITS-1:0]   CNT_RST = DIV_BITS'(DIV_GATE - 1);
    localparam logic        [DIV_BITS-1:0]   PER_RST = DIV_BITS'(DIV_GATE);

    logic        [DIV_BITS-1:0]    cnt_q, cnt_d;
    logic signed [TRIM_WIDTH-1:0]  trim_q, trim_d;
    logic signed [TRIM_WIDTH-1:0]  pend_trim_q, pend_trim_d;
    logic        [FRAC_BITS-1:0]   frac_q, frac_d;
    logic        [FRAC_BITS-1:0]   pend_frac_q, pend_frac_d;
    logic        [FRAC_BITS-1:0]   acc_q, acc_d;
    logic                          pending_q, pending_d;
    logic                          ready_q, ready_d;
    logic                          clamped_q, clamped_d;
    logic                          applied_q, applied_d;
    logic                          gate_q, gate_d;
    logic        [DIV_BITS-1:0]    period_q, period_d;
    logic        [EPOCH_WIDTH-1:0] epoch_q, epoch_d;

    logic                          accept;
    logic signed [TRIM_WIDTH-1:0]  sat_trim;
    logic                          sat_hit;
    logic signed [TRIM_WIDTH-1:0]  t_sel;
    logic        [FRAC_BITS-1:0]   f_sel;
    logic        [FRAC_BITS:0]     acc_sum;
    logic        [AW-1:0]          n_base;
    logic        [AW-1:0]          n_len;
    logic                          unused_msb;

    assign accept = i_trim_valid & ready_q;

    always_comb begin
        sat_trim = i_trim;
        sat_hit  = 1'b0;
        if (i_trim > TMAX_P) begin
            sat_trim = TMAX_P;
            sat_hit  = 1'b1;
        end else if (i_trim < TMAX_N) begin
            sat_trim = TMAX_N;
            sat_hit  = 1'b1;
        end
    end

    // A pending trim is used in the same cycle it is applied, so the new period already has it.
    assign t_sel   = pending_q ? pend_trim_q : trim_q;
    assign f_sel   = pending_q ? pend_frac_q : frac_q;
    assign acc_sum = {1'b0, acc_q} + {1'b0, f_sel};
    assign n_base  = DIV_A + AW'(t_sel);
    assign n_len   = n_base + AW'(acc_sum[FRAC_BITS]);

    // Period lengths are bounded well inside DIV_BITS, so the sign bit is never needed.
    assign unused_msb = n_base[AW-1] ^ n_len[AW-1];

    always_comb begin
        cnt_d       = cnt_q;
        trim_d      = trim_q;
        pend_trim_d = pend_trim_q;
        frac_d      = frac_q;
        pend_frac_d = pend_frac_q;
        acc_d       = acc_q;
        pending_d   = pending_q;
        ready_d     = ready_q;
        clamped_d   = 1'b0;
        applied_d   = 1'b0;
        gate_d      = 1'b0;
        period_d    = period_q;
        epoch_d     = epoch_q;

        if (applied_q) begin
            ready_d = 1'b1;
        end

        if (accept) begin
            pend_trim_d = sat_trim;
            pend_frac_d = i_frac;
            pending_d   = 1'b1;
            ready_d     = 1'b0;
            clamped_d   = sat_hit;
        end

        if (!i_en) begin
            acc_d    = '0;
            cnt_d    = n_base[DIV_BITS-1:0] - DIV_BITS'(1);
            period_d = n_base[DIV_BITS-1:0];
            if (pending_q) begin
                trim_d    = pend_trim_q;
                frac_d    = pend_frac_q;
                pending_d = 1'b0;
                applied_d = 1'b1;
            end
        end else if (cnt_q == '0) begin
            if (pending_q) begin
                trim_d    = pend_trim_q;
                frac_d    = pend_frac_q;
                pending_d = 1'b0;
                applied_d = 1'b1;
            end
            acc_d    = acc_sum[FRAC_BITS-1:0];
            cnt_d    = n_len[DIV_BITS-1:0] - DIV_BITS'(1);
            period_d = n_len[DIV_BITS-1:0];
            gate_d   = 1'b1;
            epoch_d  = epoch_q + EPOCH_WIDTH'(1);
        end else begin
            cnt_d = cnt_q - DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            cnt_q       <= CNT_RST;
            trim_q      <= '0;
            pend_trim_q <= '0;
            frac_q      <= '0;
            pend_frac_q <= '0;
            acc_q       <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            clamped_q   <= 1'b0;
            applied_q   <= 1'b0;
            gate_q      <= 1'b0;
            period_q    <= PER_RST;
            epoch_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            trim_q      <= trim_d;
            pend_trim_q <= pend_trim_d;
            frac_q      <= frac_d;
            pend_frac_q <= pend_frac_d;
            acc_q       <= acc_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            clamped_q   <= clamped_d;
            applied_q   <= applied_d;
            gate_q      <= gate_d;
            period_q    <= period_d;
            epoch_q     <= epoch_d;
        end
    end

    assign o_trim_ready   = ready_q;
    assign o_trim_clamped = clamped_q;
    assign o_trim_applied = applied_q;
    assign o_gate         = gate_q;
    assign o_period       = period_q;
    assign o_epoch        = epoch_q;

endmodule
